spi_frame_decoder: RTL
======================

# spi_frame_decoder

Downstream consumer of the oversampled SPI slave receiver. Takes the byte stream assembled by the receiver's shift register, frames it between chip-select assertion and release, validates a fixed 3-byte command frame (CMD, DATA, CHK), and executes it on CS release. It drives the board LEDs and loads the reply byte the receiver shifts out on MISO.

## Interface
Parameters:
- `CHK_SEED`, default `8'hA5`: checksum seed; valid CHK = CMD ^ DATA ^ CHK_SEED.
- `TIMEOUT_CYCLES`, default 1024: inter-byte watchdog limit in `clk_in` cycles; used only with the watchdog macro.

Ports (one clock; reset is synchronous and active-high):
- `clk_in` in 1: system clock, 25 MHz.
- `rst` in 1: synchronous, active-high reset.
- `rx_byte` in 8: byte from the receiver; valid when `rx_valid` is high.
- `rx_valid` in 1: single-cycle pulse, one per completed byte.
- `frame_start` in 1: single-cycle pulse on the synchronized CS falling edge.
- `frame_end` in 1: single-cycle pulse on the synchronized CS rising edge.
- `tx_byte` out 8: reply byte presented to the receiver's MISO shifter.
- `tx_load` out 1: single-cycle pulse; receiver latches `tx_byte`.
- `led` out 2: LED register.
- `frame_ok` out 1: single-cycle pulse; frame accepted and executed.
- `frame_err` out 1: single-cycle pulse; frame rejected.
- `err_code` out 3: reason for the last rejection; held until the next `frame_err`.

## Operation
- Commands: `0x01` WR_LED sets `led <= DATA[1:0]`. `0x02` RD_STATUS has no side effect. `0x00` NOP has no side effect. Any other value is rejected.
- Error codes:
  - 0: none.
  - 1: short frame (fewer than 3 bytes).
  - 2: long frame (more than 3 bytes).
  - 3: bad checksum.
  - 4: unknown CMD.
  - 5: timeout.
  - Priority when several apply: 5 > 1 > 2 > 4 > 3.
- FSM states: `IDLE`, `GET_CMD`, `GET_DATA`, `GET_CHK`, `WAIT_END`, `EXEC`.
  - `IDLE`: `frame_start` moves to `GET_CMD`. `rx_valid` is ignored.
  - `GET_CMD`: `rx_valid` latches CMD and moves to `GET_DATA`.
  - `GET_DATA`: `rx_valid` latches DATA and moves to `GET_CHK`.
  - `GET_CHK`: `rx_valid` latches CHK and moves to `WAIT_END`.
  - `WAIT_END`: a further `rx_valid` sets a sticky `overflow` flag.
  - Any `GET_*` state or `WAIT_END`: `frame_end` moves to `EXEC`.
  - `EXEC`: evaluates the frame, pulses `frame_ok` or `frame_err`, and returns to `IDLE` after exactly 1 cycle.
- `frame_start` in any state other than `IDLE` restarts the frame: goes to `GET_CMD` and clears the byte count and `overflow`. No error is reported.
- If `rx_valid` and `frame_end` occur in the same cycle, the byte is consumed first, then the end is evaluated. Example: third byte arriving with `frame_end` gives a 3-byte frame.
- Reply: in the cycle after CMD is latched, pulse `tx_load` with `tx_byte` set by CMD:
  - RD_STATUS: `{err_cnt[3:0], 2'b00, led}`.
  - Any other CMD: `8'h00`.
- `err_cnt`: 4-bit, incremented on every `frame_err`, saturates at 15, cleared only by `rst`.
- Checksum and compare logic is 8-bit XOR. No carries.

## Timing
- Reset values: `led=0`, `tx_byte=0`, `tx_load=0`, `frame_ok=0`, `frame_err=0`, `err_code=0`, `err_cnt=0`, state `IDLE`.
- `rst` asserted mid-frame aborts the frame with no pulse and no LED change.
- Latency:
  - `frame_ok`/`frame_err` assert 2 cycles after the `frame_end` pulse (state register, then registered output).
  - `led` updates in the same cycle as `frame_ok`.
  - `tx_load` asserts 2 cycles after the `rx_valid` that carried CMD.
- All outputs are registered. No combinational input-to-output paths.

## Configuration
- `SPI_FRAME_TIMEOUT_EN` defined:
  - A counter runs in the `GET_*` states and `WAIT_END`. It resets on each `rx_valid` and on `frame_start`.
  - Reaching `TIMEOUT_CYCLES` forces `EXEC` with error 5. After that, the module stays in `IDLE` until the next `frame_start`; the stale `frame_end` is ignored.
- `SPI_FRAME_TIMEOUT_EN` undefined: no counter and no error 5. The frame waits on CS indefinitely.

## Structure
- Package `spi_frame_pkg` holds:
  - the state enum;
  - command constants `CMD_NOP`, `CMD_WR_LED`, `CMD_RD_STATUS`;
  - the error-code enum (3-bit);
  - the default `CHK_SEED`.
- One sub-module, `spi_frame_watchdog` (loadable down-counter with expiry pulse). It is instantiated only under `SPI_FRAME_TIMEOUT_EN`.

## Test plan
- Bytes `01 02 A6`, then `frame_end` → `frame_ok` pulse; `led=2'b10`; `err_code` unchanged.
- Bytes `01 03 A5`, then `frame_end` → `frame_err`; `err_code=3`; `led` unchanged; `err_cnt=1`.
- Bytes `01 02`, then `frame_end` → `err_code=1`. Bytes `01 02 A6 FF` → `err_code=2`. Neither changes `led`.
- Bytes `02 00 A7` after two prior errors, with `led=2'b10` → `tx_load` 2 cycles after CMD; `tx_byte=8'h22`; then `frame_ok`.
- Third byte `rx_valid` coincident with `frame_end` → treated as a 3-byte frame. Separately, `rst` pulsed after the second byte → no pulse, state `IDLE`, `led=0`.
- With `SPI_FRAME_TIMEOUT_EN`, `TIMEOUT_CYCLES=16`: `frame_start`, one byte, then silence → `frame_err` with `err_code=5` within 16+2 cycles; the later `frame_end` produces no pulse.

Source files
------------

// File: rtl/spi_frame_decoder_pkg.sv
// Shared types and constants for the SPI command-frame decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package spi_frame_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_CMD  = 3'd1,
    GET_DATA = 3'd2,
    GET_CHK  = 3'd3,
    WAIT_END = 3'd4,
    EXEC     = 3'd5
  } state_e;

  localparam logic [7:0] CMD_NOP       = 8'h00;
  localparam logic [7:0] CMD_WR_LED    = 8'h01;
  localparam logic [7:0] CMD_RD_STATUS = 8'h02;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_SHORT   = 3'd1,
    ERR_LONG    = 3'd2,
    ERR_CHK     = 3'd3,
    ERR_CMD     = 3'd4,
    ERR_TIMEOUT = 3'd5
  } err_code_e;

  localparam logic [7:0] CHK_SEED_DEFAULT = 8'hA5;

  // True for the three command codes the decoder executes.
  function automatic logic cmd_known(input logic [7:0] cmd);
    return (cmd == CMD_NOP) || (cmd == CMD_WR_LED) || (cmd == CMD_RD_STATUS);
  endfunction

endpackage

// File: rtl/spi_frame_decoder_if.sv
// Byte/framing bus between the SPI slave receiver and the frame decoder.
// Latency: n/a (wires only).
// Backpressure: none; every strobe is a single-cycle pulse that must be taken.
interface spi_frame_decoder_if;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_start;
  logic       frame_end;
  logic [7:0] tx_byte;
  logic       tx_load;

  modport master (
    output rx_byte, rx_valid, frame_start, frame_end,
    input  tx_byte, tx_load
  );

  modport slave (
    input  rx_byte, rx_valid, frame_start, frame_end,
    output tx_byte, tx_load
  );
endinterface

// File: rtl/spi_frame_decoder_watchdog.sv
// Loadable down-counter; expire pulses once TIMEOUT_CYCLES enabled cycles pass without a load.
// Latency: expire is combinational from the count, asserted in the TIMEOUT_CYCLES-th cycle after load.
// Backpressure: none; load always wins over counting.
module spi_frame_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk_in,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LOAD_VAL = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Reload on activity, otherwise count down while the frame is open.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  assign expire = en && !load && (cnt_q == '0);

  // Counter register.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt_q <= LOAD_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_frame_decoder.sv
// Frames SPI bytes between CS edges, validates CMD/DATA/CHK and executes on CS release.
// Latency: frame_ok/frame_err 2 cycles after frame_end; tx_load 2 cycles after the CMD byte.
// Backpressure: none; optional inter-byte watchdog under SPI_FRAME_TIMEOUT_EN.
module spi_frame_decoder
  import spi_frame_pkg::*;
#(
  parameter logic [7:0]  CHK_SEED       = CHK_SEED_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_in,
  input  logic                  rst,
  spi_frame_decoder_if.slave    bus,
  output logic [1:0]            led,
  output logic                  frame_ok,
  output logic                  frame_err,
  output logic [2:0]            err_code
);

  state_e     state_q, state_d;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] data_q, data_d;
  logic [7:0] chk_q, chk_d;
  logic [1:0] cnt_q, cnt_d;
  logic       ovf_q, ovf_d;
  logic       to_q, to_d;
  logic       cmd_new_q, cmd_new_d;
  logic [1:0] led_q, led_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic       tx_load_q, tx_load_d;
  logic       frame_ok_q, frame_ok_d;
  logic       frame_err_q, frame_err_d;
  err_code_e  err_code_q, err_code_d;
  logic [3:0] err_cnt_q, err_cnt_d;
  err_code_e  eval_code;
  logic       in_frame;
  logic       timeout_hit;

  assign in_frame = (state_q == GET_CMD) || (state_q == GET_DATA) ||
                    (state_q == GET_CHK) || (state_q == WAIT_END);

`ifdef SPI_FRAME_TIMEOUT_EN
  spi_frame_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wdog (
    .clk_in (clk_in),
    .rst    (rst),
    .load   (bus.rx_valid | bus.frame_start),
    .en     (in_frame),
    .expire (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: restart beats timeout beats CS release beats byte advance.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.frame_start) state_d = GET_CMD;
      end
      GET_CMD, GET_DATA, GET_CHK, WAIT_END: begin
        if (bus.frame_start) begin
          state_d = GET_CMD;
        end else if (timeout_hit || bus.frame_end) begin
          state_d = EXEC;
        end else if (bus.rx_valid) begin
          case (state_q)
            GET_CMD:  state_d = GET_DATA;
            GET_DATA: state_d = GET_CHK;
            default:  state_d = WAIT_END;
          endcase
        end
      end
      EXEC: begin
        state_d = bus.frame_start ? GET_CMD : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and outputs: byte capture, reply load and frame evaluation.
  always_comb begin
    cmd_d       = cmd_q;
    data_d      = data_q;
    chk_d       = chk_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    to_d        = to_q;
    cmd_new_d   = 1'b0;
    led_d       = led_q;
    tx_byte_d   = tx_byte_q;
    tx_load_d   = 1'b0;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    err_cnt_d   = err_cnt_q;
    eval_code   = ERR_NONE;

    // Byte capture; a byte coincident with frame_end is still taken.
    if (bus.frame_start) begin
      cnt_d = 2'd0;
      ovf_d = 1'b0;
      to_d  = 1'b0;
    end else if (in_frame) begin
      if (timeout_hit) to_d = 1'b1;
      if (bus.rx_valid) begin
        case (state_q)
          GET_CMD: begin
            cmd_d     = bus.rx_byte;
            cnt_d     = 2'd1;
            cmd_new_d = 1'b1;
          end
          GET_DATA: begin
            data_d = bus.rx_byte;
            cnt_d  = 2'd2;
          end
          GET_CHK: begin
            chk_d = bus.rx_byte;
            cnt_d = 2'd3;
          end
          default: ovf_d = 1'b1;
        endcase
      end
    end

    // Reply byte is loaded the cycle after CMD lands.
    if (cmd_new_q) begin
      tx_load_d = 1'b1;
      tx_byte_d = (cmd_q == CMD_RD_STATUS) ? {err_cnt_q, 2'b00, led_q} : 8'h00;
    end

    // Evaluate in priority timeout > short > long > unknown cmd > checksum.
    if (state_q == EXEC) begin
      if (to_q) begin
        eval_code = ERR_TIMEOUT;
      end else if (cnt_q != 2'd3) begin
        eval_code = ERR_SHORT;
      end else if (ovf_q) begin
        eval_code = ERR_LONG;
      end else if (!cmd_known(cmd_q)) begin
        eval_code = ERR_CMD;
      end else if (chk_q != (cmd_q ^ data_q ^ CHK_SEED)) begin
        eval_code = ERR_CHK;
      end

      if (eval_code == ERR_NONE) begin
        frame_ok_d = 1'b1;
        if (cmd_q == CMD_WR_LED) led_d = data_q[1:0];
      end else begin
        frame_err_d = 1'b1;
        err_code_d  = eval_code;
        if (err_cnt_q != 4'hF) err_cnt_d = err_cnt_q + 4'd1;
      end
      to_d = 1'b0;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      cmd_q       <= 8'h00;
      data_q      <= 8'h00;
      chk_q       <= 8'h00;
      cnt_q       <= 2'd0;
      ovf_q       <= 1'b0;
      to_q        <= 1'b0;
      cmd_new_q   <= 1'b0;
      led_q       <= 2'b00;
      tx_byte_q   <= 8'h00;
      tx_load_q   <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      err_cnt_q   <= 4'd0;
    end else begin
      cmd_q       <= cmd_d;
      data_q      <= data_d;
      chk_q       <= chk_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      to_q        <= to_d;
      cmd_new_q   <= cmd_new_d;
      led_q       <= led_d;
      tx_byte_q   <= tx_byte_d;
      tx_load_q   <= tx_load_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.tx_byte = tx_byte_q;
  assign bus.tx_load = tx_load_q;
  assign led         = led_q;
  assign frame_ok    = frame_ok_q;
  assign frame_err   = frame_err_q;
  assign err_code    = err_code_q;

endmodule
